// File: rtl/luks_pkg.sv
// luks_pkg: shared constants for the lux/exposure meter mode controller.
// Holds the menu mode encoding, the press-event encoding, the index width
// and a saturating step helper used by the shutter/aperture index registers.
package luks_pkg;

  localparam int IDX_W = 4;

  // Menu modes, also the encoding seen on the mode output pins
  localparam logic [1:0] MODE_IDLE = 2'd0;
  localparam logic [1:0] MODE_SS   = 2'd1;
  localparam logic [1:0] MODE_F    = 2'd2;
  localparam logic [1:0] MODE_EXP  = 2'd3;

  // Button press classes produced by the classifier
  localparam logic [1:0] EV_NONE   = 2'd0;
  localparam logic [1:0] EV_SHORT  = 2'd1;
  localparam logic [1:0] EV_MEDIUM = 2'd2;
  localparam logic [1:0] EV_LONG   = 2'd3;

  // One saturating step of an index; simultaneous up and down cancel out.
  function automatic logic [IDX_W-1:0] step_idx(input logic [IDX_W-1:0] cur,
                                                input logic             up,
                                                input logic             dn,
                                                input logic [IDX_W-1:0] max_v);
    logic [IDX_W-1:0] nxt;
    nxt = cur;
    if (up && !dn && (cur < max_v))
      nxt = cur + 1'b1;
    else if (dn && !up && (cur != '0))
      nxt = cur - 1'b1;
    return nxt;
  endfunction

endpackage

// File: rtl/luks_pb_classifier.sv
// luks_pb_classifier: turns the raw active-low pushbutton into press events.
// Two-flop synchronizer, debounce counter, then a hold counter that sorts
// each press into short / medium / long.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   ena         when low every register holds
//   pb_n        raw pushbutton, active low, asynchronous
//   ev          press class (EV_SHORT, EV_MEDIUM, EV_LONG), valid with ev_valid
//   ev_valid    one-cycle strobe qualifying ev
module luks_pb_classifier
  import luks_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned MEDIUM_CYC   = 200,
  parameter int unsigned LONG_CYC     = 800
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       pb_n,
  output logic [1:0] ev,
  output logic       ev_valid
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int HW = $clog2(LONG_CYC + 1);

  logic          sync1;
  logic          sync2;
  logic          db_pressed;
  logic [DW-1:0] db_cnt;
  logic [HW-1:0] hold_cnt;
  logic          sync_pressed;
  logic          db_flip;

  assign sync_pressed = ~sync2;

  // The debounced level flips on the edge of the DEBOUNCE_CYC-th
  // consecutive sample that disagrees with it.
  assign db_flip = (sync_pressed != db_pressed) &&
                   (db_cnt == DW'(DEBOUNCE_CYC - 1));

  // Synchronizer, debounce and hold counter. A release event is produced on
  // the same edge the debounced level returns to released, so it is seen
  // 2 + DEBOUNCE_CYC cycles after the raw edge. A press that already fired
  // a long event leaves hold_cnt saturated, which suppresses the release event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      db_pressed <= 1'b0;
      db_cnt     <= '0;
      hold_cnt   <= '0;
      ev         <= EV_NONE;
      ev_valid   <= 1'b0;
    end else if (ena) begin
      sync1    <= pb_n;
      sync2    <= sync1;
      ev       <= EV_NONE;
      ev_valid <= 1'b0;

      if (db_flip) begin
        db_pressed <= sync_pressed;
        db_cnt     <= '0;
      end else if (sync_pressed != db_pressed) begin
        db_cnt <= db_cnt + 1'b1;
      end else begin
        db_cnt <= '0;
      end

      if (db_flip && db_pressed) begin
        hold_cnt <= '0;
        if (hold_cnt < HW'(LONG_CYC)) begin
          ev_valid <= 1'b1;
          ev       <= (hold_cnt < HW'(MEDIUM_CYC)) ? EV_SHORT : EV_MEDIUM;
        end
      end else if (db_pressed && (hold_cnt < HW'(LONG_CYC))) begin
        hold_cnt <= hold_cnt + 1'b1;
        if (hold_cnt == HW'(LONG_CYC - 1)) begin
          ev_valid <= 1'b1;
          ev       <= EV_LONG;
        end
      end
    end
  end

endmodule

// File: rtl/luks_mode_ctrl.sv
// luks_mode_ctrl: menu state machine of the lux/exposure meter.
// Consumes button press events, holds the shutter-speed and f-number
// indices, and sequences the exposure datapath with a start/done handshake
// guarded by a timeout.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   ena             design enable; low freezes all state
//   pb_n            raw active-low pushbutton
//   adj_up, adj_dn  single-cycle encoder step pulses
//   meas_done       single-cycle datapath completion pulse
//   mode            0=IDLE 1=SS_SEL 2=F_SEL 3=EXP_METER
//   ss_idx, f_idx   shutter-speed and f-number indices
//   meas_start      single-cycle measurement request
//   meas_busy       measurement in flight
//   meas_err        sticky timeout flag, cleared by the next meas_start
module luks_mode_ctrl
  import luks_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned MEDIUM_CYC   = 200,
  parameter int unsigned LONG_CYC     = 800,
  parameter int unsigned SS_MAX       = 11,
  parameter int unsigned F_MAX        = 9,
  parameter int unsigned SS_DEF       = 6,
  parameter int unsigned F_DEF        = 4,
  parameter int unsigned TIMEOUT_CYC  = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             pb_n,
  input  logic             adj_up,
  input  logic             adj_dn,
  input  logic             meas_done,
  output logic [1:0]       mode,
  output logic [IDX_W-1:0] ss_idx,
  output logic [IDX_W-1:0] f_idx,
  output logic             meas_start,
  output logic             meas_busy,
  output logic             meas_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]    ev;
  logic          ev_valid;
  logic          start_q;
  logic [TW-1:0] tmo_cnt;

  luks_pb_classifier #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .MEDIUM_CYC   (MEDIUM_CYC),
    .LONG_CYC     (LONG_CYC)
  ) u_classifier (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .pb_n     (pb_n),
    .ev       (ev),
    .ev_valid (ev_valid)
  );

  // The start request is held in start_q while disabled, so an entry pulse
  // that coincides with ena low is delivered once ena comes back.
  assign meas_start = start_q & ena;

  // Handshake first, then adjust (using the pre-transition mode), then the
  // button event; later assignments take priority so entering or leaving
  // EXP_METER overrides whatever the handshake decided this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode      <= MODE_IDLE;
      ss_idx    <= IDX_W'(SS_DEF);
      f_idx     <= IDX_W'(F_DEF);
      start_q   <= 1'b0;
      meas_busy <= 1'b0;
      meas_err  <= 1'b0;
      tmo_cnt   <= '0;
    end else if (ena) begin
      start_q <= 1'b0;

      if (meas_busy) begin
        if (meas_done) begin
          meas_busy <= 1'b0;
          tmo_cnt   <= '0;
        end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
          meas_busy <= 1'b0;
          meas_err  <= 1'b1;
          tmo_cnt   <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end

      if (mode == MODE_SS)
        ss_idx <= step_idx(ss_idx, adj_up, adj_dn, IDX_W'(SS_MAX));
      if (mode == MODE_F)
        f_idx <= step_idx(f_idx, adj_up, adj_dn, IDX_W'(F_MAX));

      if (ev_valid) begin
        case (ev)
          EV_LONG: begin
            mode      <= MODE_IDLE;
            ss_idx    <= IDX_W'(SS_DEF);
            f_idx     <= IDX_W'(F_DEF);
            meas_busy <= 1'b0;
            tmo_cnt   <= '0;
          end
          EV_SHORT: begin
            case (mode)
              MODE_IDLE: mode <= MODE_SS;
              MODE_SS:   mode <= MODE_F;
              MODE_F:    mode <= MODE_SS;
              default: begin
                if (!meas_busy) begin
                  start_q   <= 1'b1;
                  meas_busy <= 1'b1;
                  meas_err  <= 1'b0;
                  tmo_cnt   <= '0;
                end
              end
            endcase
          end
          EV_MEDIUM: begin
            if (mode == MODE_EXP) begin
              mode      <= MODE_IDLE;
              meas_busy <= 1'b0;
              tmo_cnt   <= '0;
            end else begin
              mode      <= MODE_EXP;
              start_q   <= 1'b1;
              meas_busy <= 1'b1;
              meas_err  <= 1'b0;
              tmo_cnt   <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_luks_mode_ctrl.sv
// tb_luks_mode_ctrl: directed bench for luks_mode_ctrl.
// A table of press/adjust vectors walks the menu, followed by hand-written
// sequences for the measurement handshake, timeout, long press, glitch
// rejection, enable freeze and asynchronous reset.
module tb_luks_mode_ctrl;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       pb_n;
  logic       adj_up;
  logic       adj_dn;
  logic       meas_done;
  logic [1:0] mode;
  logic [3:0] ss_idx;
  logic [3:0] f_idx;
  logic       meas_start;
  logic       meas_busy;
  logic       meas_err;

  int checks = 0;
  int errors = 0;
  int start_count = 0;

  typedef struct {
    bit         is_press;
    int         press_len;
    bit         up;
    bit         dn;
    logic [1:0] exp_mode;
    logic [3:0] exp_ss;
    logic [3:0] exp_f;
  } vec_t;

  vec_t vecs[$];

  luks_mode_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .pb_n       (pb_n),
    .adj_up     (adj_up),
    .adj_dn     (adj_dn),
    .meas_done  (meas_done),
    .mode       (mode),
    .ss_idx     (ss_idx),
    .f_idx      (f_idx),
    .meas_start (meas_start),
    .meas_busy  (meas_busy),
    .meas_err   (meas_err)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts cycles on which meas_start is high, sampled mid-cycle after
  // any input changes made at the falling edge.
  always begin
    @(negedge clk);
    #2;
    if (meas_start) start_count++;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic press_button(input int len);
    pb_n = 1'b0;
    repeat (len) @(negedge clk);
    pb_n = 1'b1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_start(input int budget, input string name);
    bit found;
    found = 1'b0;
    for (int c = 0; c < budget && !found; c++) begin
      @(negedge clk);
      if (meas_start) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL %s: meas_start got 0 within %0d cycles, expected 1", name, budget);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.is_press) begin
      press_button(v.press_len);
      wait_cycles(20);
    end else begin
      adj_up = v.up;
      adj_dn = v.dn;
      @(negedge clk);
      adj_up = 1'b0;
      adj_dn = 1'b0;
      @(negedge clk);
    end
  endtask

  function automatic void add_vec(input bit p, input int len, input bit up, input bit dn,
                                  input logic [1:0] m, input logic [3:0] s, input logic [3:0] f);
    vec_t v;
    v.is_press  = p;
    v.press_len = len;
    v.up        = up;
    v.dn        = dn;
    v.exp_mode  = m;
    v.exp_ss    = s;
    v.exp_f     = f;
    vecs.push_back(v);
  endfunction

  initial begin
    int lows;

    rst_n     = 1'b0;
    ena       = 1'b1;
    pb_n      = 1'b1;
    adj_up    = 1'b0;
    adj_dn    = 1'b0;
    meas_done = 1'b0;

    // Menu walk: adjust ignored in IDLE, SS stepping, cancel on up+dn,
    // F stepping saturating at 0, SS saturating at SS_MAX.
    add_vec(0, 0,   1, 0, 2'd0, 4'd6,  4'd4);
    add_vec(1, 100, 0, 0, 2'd1, 4'd6,  4'd4);
    add_vec(0, 0,   1, 0, 2'd1, 4'd7,  4'd4);
    add_vec(0, 0,   1, 0, 2'd1, 4'd8,  4'd4);
    add_vec(0, 0,   1, 0, 2'd1, 4'd9,  4'd4);
    add_vec(0, 0,   1, 1, 2'd1, 4'd9,  4'd4);
    add_vec(1, 100, 0, 0, 2'd2, 4'd9,  4'd4);
    add_vec(0, 0,   0, 1, 2'd2, 4'd9,  4'd3);
    add_vec(0, 0,   0, 1, 2'd2, 4'd9,  4'd2);
    add_vec(0, 0,   0, 1, 2'd2, 4'd9,  4'd1);
    add_vec(0, 0,   0, 1, 2'd2, 4'd9,  4'd0);
    add_vec(0, 0,   0, 1, 2'd2, 4'd9,  4'd0);
    add_vec(0, 0,   0, 1, 2'd2, 4'd9,  4'd0);
    add_vec(0, 0,   1, 0, 2'd2, 4'd9,  4'd1);
    add_vec(1, 100, 0, 0, 2'd1, 4'd9,  4'd1);
    add_vec(0, 0,   1, 0, 2'd1, 4'd10, 4'd1);
    add_vec(0, 0,   1, 0, 2'd1, 4'd11, 4'd1);
    add_vec(0, 0,   1, 0, 2'd1, 4'd11, 4'd1);
    add_vec(1, 100, 0, 0, 2'd2, 4'd11, 4'd1);

    // Reset state
    wait_cycles(3);
    checkOutput("rst_mode", mode, 0);
    checkOutput("rst_ss", ss_idx, 6);
    checkOutput("rst_f", f_idx, 4);
    checkOutput("rst_start", meas_start, 0);
    checkOutput("rst_busy", meas_busy, 0);
    checkOutput("rst_err", meas_err, 0);
    rst_n = 1'b1;
    wait_cycles(3);

    $display("[TB] menu vector table");
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_mode", i), mode, vecs[i].exp_mode);
      checkOutput($sformatf("vec%0d_ss", i), ss_idx, vecs[i].exp_ss);
      checkOutput($sformatf("vec%0d_f", i), f_idx, vecs[i].exp_f);
    end
    checkOutput("menu_no_start", start_count, 0);

    $display("[TB] medium press into EXP_METER, done after 50 cycles");
    press_button(400);
    wait_start(40, "exp_entry_start");
    checkOutput("exp_entry_mode", mode, 3);
    checkOutput("exp_entry_busy", meas_busy, 1);
    checkOutput("exp_entry_err", meas_err, 0);
    wait_cycles(3);
    checkOutput("exp_entry_single_pulse", start_count, 1);
    wait_cycles(47);
    checkOutput("done_busy_before", meas_busy, 1);
    meas_done = 1'b1;
    @(negedge clk);
    meas_done = 1'b0;
    checkOutput("done_busy_drop", meas_busy, 0);
    checkOutput("done_err", meas_err, 0);

    $display("[TB] retrigger and timeout");
    press_button(100);
    wait_start(40, "retrig_start");
    lows = 0;
    for (int i = 1; i <= 999; i++) begin
      @(negedge clk);
      if (!meas_busy) lows++;
    end
    checkOutput("tmo_busy_held_999", lows, 0);
    checkOutput("tmo_err_early", meas_err, 0);
    @(negedge clk);
    checkOutput("tmo_busy_drop_1000", meas_busy, 0);
    checkOutput("tmo_err_set", meas_err, 1);
    press_button(100);
    wait_start(40, "after_tmo_start");
    checkOutput("after_tmo_err_clr", meas_err, 0);
    checkOutput("after_tmo_busy", meas_busy, 1);

    $display("[TB] long press while busy");
    pb_n = 1'b0;
    wait_cycles(780);
    checkOutput("long_pre_mode", mode, 3);
    wait_cycles(50);
    checkOutput("long_mode_idle", mode, 0);
    checkOutput("long_ss_def", ss_idx, 6);
    checkOutput("long_f_def", f_idx, 4);
    checkOutput("long_busy_clr", meas_busy, 0);
    checkOutput("long_no_err", meas_err, 0);
    wait_cycles(70);
    pb_n = 1'b1;
    wait_cycles(20);
    checkOutput("long_release_no_event", mode, 0);
    meas_done = 1'b1;
    @(negedge clk);
    meas_done = 1'b0;
    wait_cycles(2);
    checkOutput("stale_done_busy", meas_busy, 0);
    checkOutput("stale_done_err", meas_err, 0);
    checkOutput("start_total_3", start_count, 3);

    $display("[TB] glitch rejection");
    press_button(2);
    wait_cycles(20);
    checkOutput("glitch_mode", mode, 0);

    $display("[TB] enable freeze mid-press");
    pb_n = 1'b0;
    wait_cycles(50);
    ena = 1'b0;
    wait_cycles(300);
    checkOutput("freeze_press_mode", mode, 0);
    ena = 1'b1;
    wait_cycles(100);
    pb_n = 1'b1;
    wait_cycles(20);
    checkOutput("freeze_press_short", mode, 1);
    ena = 1'b0;
    adj_up = 1'b1;
    @(negedge clk);
    adj_up = 1'b0;
    wait_cycles(2);
    ena = 1'b1;
    wait_cycles(2);
    checkOutput("freeze_adj_dropped", ss_idx, 6);

    $display("[TB] enable freeze on entry and mid-measurement");
    press_button(300);
    wait_start(40, "freeze_exp_start");
    ena = 1'b0;
    #1;
    checkOutput("freeze_start_forced", meas_start, 0);
    checkOutput("freeze_exp_mode", mode, 3);
    wait_cycles(150);
    meas_done = 1'b1;
    @(negedge clk);
    meas_done = 1'b0;
    wait_cycles(149);
    checkOutput("freeze_busy_held", meas_busy, 1);
    ena = 1'b1;
    #1;
    checkOutput("freeze_start_pending", meas_start, 1);
    @(negedge clk);
    checkOutput("freeze_start_cleared", meas_start, 0);
    checkOutput("freeze_done_dropped", meas_busy, 1);
    press_button(100);
    wait_cycles(20);
    checkOutput("busy_short_ignored", start_count, 4);
    wait_cycles(700);
    checkOutput("freeze_tmo_frozen", meas_busy, 1);
    wait_cycles(250);
    checkOutput("freeze_tmo_busy", meas_busy, 0);
    checkOutput("freeze_tmo_err", meas_err, 1);

    $display("[TB] async reset mid-press");
    pb_n = 1'b0;
    wait_cycles(100);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_mode", mode, 0);
    checkOutput("arst_ss", ss_idx, 6);
    checkOutput("arst_f", f_idx, 4);
    checkOutput("arst_busy", meas_busy, 0);
    checkOutput("arst_err", meas_err, 0);
    checkOutput("arst_start", meas_start, 0);
    @(negedge clk);
    pb_n = 1'b1;
    rst_n = 1'b1;
    wait_cycles(30);
    checkOutput("arst_no_event", mode, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
